decode_fetch_queue: RTL and testbench

DECODE_FETCH_QUEUE -- requirements
Module: decode_fetch_queue

---
 rtl/decode_fetch_queue_pkg.sv | 19 +
 rtl/decode_fetch_queue_if.sv | 30 +++
 rtl/decode_fetch_queue_dq_predecode.sv | 28 ++
 rtl/decode_fetch_queue.sv | 102 ++++++++++
 tb/tb_decode_fetch_queue.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/decode_fetch_queue_pkg.sv
// Shared decode constants: DQ-form opcodes, sub-opcodes and default widths.
// Latency: n/a (constants only).
// Backpressure: n/a.
package decode_fetch_queue_pkg;

  localparam int DEFAULT_INSTRUCTION_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH        = 64;
  localparam int DEFAULT_OPCODE_WIDTH      = 6;
  localparam int DEFAULT_DEPTH             = 4;

  // Primary opcodes that carry DQ-form loads/stores
  localparam logic [5:0] OPC_DQ_LOAD = 6'd56;
  localparam logic [5:0] OPC_DQ_EXT  = 6'd61;

  // Sub-opcode values in bits [29:31] that select DQ form under OPC_DQ_EXT
  localparam logic [2:0] DQ_XO_A = 3'd1;
  localparam logic [2:0] DQ_XO_B = 3'd2;

endpackage

// File: rtl/decode_fetch_queue_if.sv
// Fetch-to-decode queue bus: fetch offer, fetch stall, decode presentation.
// Latency: n/a (wiring only).
// Backpressure: stall_o toward fetch, stall_i from the format decoders.
interface decode_fetch_queue_if #(
  parameter int instructionWidth = 32,
  parameter int addrWidth        = 64
);
  logic                        flush_i;
  logic                        enable_i;
  logic [0:instructionWidth-1] instruction_i;
  logic [0:addrWidth-1]        address_i;
  logic                        stall_o;
  logic                        stall_i;
  logic [0:instructionWidth-1] instruction_o;
  logic [0:addrWidth-1]        address_o;
  logic                        isDQ_o;
  logic                        enable_o;

  // Queue side
  modport slave (
    input  flush_i, enable_i, instruction_i, address_i, stall_i,
    output stall_o, instruction_o, address_o, isDQ_o, enable_o
  );

  // Fetch/decode environment side
  modport master (
    output flush_i, enable_i, instruction_i, address_i, stall_i,
    input  stall_o, instruction_o, address_o, isDQ_o, enable_o
  );
endinterface

// File: rtl/decode_fetch_queue_dq_predecode.sv
// Tags DQ-form loads/stores from the primary opcode and low sub-opcode bits.
// Latency: combinational.
// Backpressure: none.
module dq_predecode
  import decode_fetch_queue_pkg::*;
#(
  parameter int instructionWidth = DEFAULT_INSTRUCTION_WIDTH,
  parameter int opcodeWidth      = DEFAULT_OPCODE_WIDTH
) (
  input  logic [0:instructionWidth-1] i_instruction,
  output logic                        o_isDQ
);
  logic [0:opcodeWidth-1] w_opcode;
  logic [0:2]             w_xo;

  assign w_opcode = i_instruction[0:opcodeWidth-1];
  assign w_xo     = i_instruction[instructionWidth-3:instructionWidth-1];

  // Opcode 56 is always DQ; opcode 61 only for the two DQ sub-opcodes
  always_comb begin
    o_isDQ = 1'b0;
    if (w_opcode == opcodeWidth'(OPC_DQ_LOAD)) begin
      o_isDQ = 1'b1;
    end else if (w_opcode == opcodeWidth'(OPC_DQ_EXT)) begin
      o_isDQ = (w_xo == DQ_XO_A) || (w_xo == DQ_XO_B);
    end
  end
endmodule

// File: rtl/decode_fetch_queue.sv
// Circular instruction queue between fetch and the format decoders, predecodes isDQ.
// Latency: one edge from head-of-queue to registered presentation; no bypass.
// Backpressure: stall_o when full (offers dropped); stall_i freezes outputs.
module decode_fetch_queue
  import decode_fetch_queue_pkg::*;
#(
  parameter int instructionWidth = DEFAULT_INSTRUCTION_WIDTH,
  parameter int addrWidth        = DEFAULT_ADDR_WIDTH,
  parameter int opcodeWidth      = DEFAULT_OPCODE_WIDTH,
  parameter int depth            = DEFAULT_DEPTH
) (
  input logic                 clock_i,
  input logic                 reset_i,
  decode_fetch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(depth);

  // Storage, intentionally without reset
  logic [0:instructionWidth-1] r_mem_instr [depth];
  logic [0:addrWidth-1]        r_mem_addr  [depth];
  logic                        r_mem_dq    [depth];

  logic [PTR_W-1:0]            r_head;
  logic [PTR_W-1:0]            r_tail;
  logic [CNT_W-1:0]            r_count;

  logic [0:instructionWidth-1] r_instruction;
  logic [0:addrWidth-1]        r_address;
  logic                        r_isDQ;
  logic                        r_enable;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_isDQ;

  dq_predecode #(
    .instructionWidth (instructionWidth),
    .opcodeWidth      (opcodeWidth)
  ) u_dq_predecode (
    .i_instruction (bus.instruction_i),
    .o_isDQ        (w_isDQ)
  );

  // Full is judged on the pre-edge count, so a same-edge pop never frees a slot for the offer
  assign w_full = (r_count == FULL_CNT);
  assign w_push = bus.enable_i && !w_full && !bus.flush_i;
  assign w_pop  = !bus.stall_i && (r_count != '0) && !bus.flush_i;

  assign bus.stall_o       = w_full;
  assign bus.instruction_o = r_instruction;
  assign bus.address_o     = r_address;
  assign bus.isDQ_o        = r_isDQ;
  assign bus.enable_o      = r_enable;

  // Write the offered entry, with its predecode tag, at the tail
  always_ff @(posedge clock_i) begin
    if (w_push && !reset_i) begin
      r_mem_instr[r_tail] <= bus.instruction_i;
      r_mem_addr[r_tail]  <= bus.address_i;
      r_mem_dq[r_tail]    <= w_isDQ;
    end
  end

  // Pointer/count bookkeeping and registered presentation of the head entry
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_enable      <= 1'b0;
      r_instruction <= '0;
      r_address     <= '0;
      r_isDQ        <= 1'b0;
    end else if (bus.flush_i) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_enable <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head        <= r_head + 1'b1;
        r_instruction <= r_mem_instr[r_head];
        r_address     <= r_mem_addr[r_head];
        r_isDQ        <= r_mem_dq[r_head];
        r_enable      <= 1'b1;
      end else if (!bus.stall_i) begin
        r_enable <= 1'b0;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_decode_fetch_queue.sv
// Directed plus randomized bench for decode_fetch_queue against a queue-based model.
// Latency: n/a.
// Backpressure: stall_i driven randomly; fetch re-offers are modelled explicitly.
module tb_decode_fetch_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] w;
    logic [63:0] a;
  } entry_t;

  logic clock_i;
  logic reset_i;
  int   checks;
  int   errors;

  entry_t      mq[$];
  logic        m_en;
  logic [31:0] m_w;
  logic [63:0] m_a;
  logic        m_dq;

  decode_fetch_queue_if #(.instructionWidth(32), .addrWidth(64)) bus ();

  decode_fetch_queue #(
    .instructionWidth (32),
    .addrWidth        (64),
    .opcodeWidth      (6),
    .depth            (DEPTH)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  function automatic logic is_dq(input logic [31:0] w);
    int op;
    int xo;
    op = int'(w[31:26]);
    xo = int'(w[2:0]);
    return (op == 56) || (op == 61 && (xo == 1 || xo == 2));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic step(input logic rst, input logic fl, input logic en, input logic st,
                      input logic [31:0] w, input logic [63:0] a);
    int     n;
    entry_t e;
    reset_i           = rst;
    bus.flush_i       = fl;
    bus.enable_i      = en;
    bus.stall_i       = st;
    bus.instruction_i = w;
    bus.address_i     = a;
    if (rst) begin
      mq.delete();
      m_en = 1'b0; m_w = '0; m_a = '0; m_dq = 1'b0;
    end else if (fl) begin
      mq.delete();
      m_en = 1'b0;
    end else begin
      n = mq.size();
      if (!st) begin
        if (n > 0) begin
          e = mq.pop_front();
          m_en = 1'b1; m_w = e.w; m_a = e.a; m_dq = is_dq(e.w);
        end else begin
          m_en = 1'b0;
        end
      end
      if (en && n < DEPTH) begin
        e.w = w; e.a = a;
        mq.push_back(e);
      end
    end
    @(posedge clock_i);
    #1;
    check("enable_o", 64'(bus.enable_o), 64'(m_en));
    check("stall_o", 64'(bus.stall_o), 64'(mq.size() == DEPTH));
    check("instruction_o", 64'(bus.instruction_o), 64'(m_w));
    check("address_o", bus.address_o, m_a);
    check("isDQ_o", 64'(bus.isDQ_o), 64'(m_dq));
  endtask

  function automatic logic [63:0] raddr();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [31:0] w;
    int          r;
    checks = 0;
    errors = 0;
    reset_i = 1'b1;
    bus.flush_i = 1'b0; bus.enable_i = 1'b0; bus.stall_i = 1'b0;
    bus.instruction_i = '0; bus.address_i = '0;
    m_en = 1'b0; m_w = '0; m_a = '0; m_dq = 1'b0;
    @(negedge clock_i);

    // Reset state
    step(1, 0, 0, 0, 32'h0, 64'h0);
    step(1, 0, 1, 0, 32'hDEADBEEF, 64'h1);
    check("reset_enable_o", 64'(bus.enable_o), 64'h0);
    check("reset_stall_o", 64'(bus.stall_o), 64'h0);

    // Opcode 56 single instruction through an empty queue
    step(0, 0, 1, 0, 32'hE0000000, 64'h1000);
    step(0, 0, 0, 0, 32'h0, 64'h0);
    check("dq56_enable_o", 64'(bus.enable_o), 64'h1);
    check("dq56_instruction_o", 64'(bus.instruction_o), 64'hE0000000);
    check("dq56_isDQ_o", 64'(bus.isDQ_o), 64'h1);
    step(0, 0, 0, 0, 32'h0, 64'h0);

    // Fill while stalled, fifth offer dropped, then drain in order
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1, 32'h1111_0000 + 32'(i), 64'h2000 + 64'(i * 4));
      if (i == 3) check("full_after_4_stall_o", 64'(bus.stall_o), 64'h1);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 32'h0, 64'h0);
      if (i < 4) check("drain_order", 64'(bus.instruction_o), 64'h1111_0000 + 64'(i));
    end

    // Full queue with a pop and an offer at the same edge
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 32'h2222_0000 + 32'(i), raddr());
    step(0, 0, 1, 0, 32'h2222_00AA, 64'hAA);
    check("full_pop_refuse_stall_o", 64'(bus.stall_o), 64'h0);
    step(0, 0, 1, 1, 32'h2222_00AA, 64'hAA);
    check("reoffer_accept_stall_o", 64'(bus.stall_o), 64'h1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 32'h0, 64'h0);

    // Opcode 61 sub-opcode decoding
    step(0, 0, 1, 0, {6'd61, 23'h0, 3'd3}, 64'h3000);
    step(0, 0, 1, 0, {6'd61, 23'h0, 3'd2}, 64'h3004);
    check("op61_xo3_isDQ_o", 64'(bus.isDQ_o), 64'h0);
    step(0, 0, 0, 0, 32'h0, 64'h0);
    check("op61_xo2_isDQ_o", 64'(bus.isDQ_o), 64'h1);
    step(0, 0, 0, 0, 32'h0, 64'h0);

    // Flush with three queued entries and a simultaneous offer
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'h3333_0000 + 32'(i), raddr());
    step(0, 1, 1, 0, 32'h3333_00FF, 64'hFF);
    check("flush_enable_o", 64'(bus.enable_o), 64'h0);
    check("flush_stall_o", 64'(bus.stall_o), 64'h0);
    step(0, 0, 1, 0, 32'h4444_0001, 64'h4000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0, 64'h0);

    // Reset mid-stream, then wrap the pointers
    step(0, 0, 1, 1, 32'h5555_0000, raddr());
    step(0, 0, 1, 1, 32'h5555_0001, raddr());
    step(1, 1, 1, 0, 32'h5555_0002, raddr());
    check("midreset_instruction_o", 64'(bus.instruction_o), 64'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 32'h6666_0000 + 32'(i), raddr());
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0, 64'h0);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      w = $urandom;
      case ($urandom_range(0, 3))
        0: w[31:26] = 6'd56;
        1: begin w[31:26] = 6'd61; w[2:0] = 3'($urandom_range(0, 7)); end
        default: ;
      endcase
      step(r == 0, r >= 1 && r <= 3, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           w, raddr());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
